// File: rtl/video_scandbl_line_if.sv
// video_scandbl_line_if: pixel strobes from the mixer and sync generators, plus doubled VGA colour back out
interface video_scandbl_line_if;
  logic [11:0] in_color;
  logic        in_stb;
  logic        in_line_start;
  logic        vga_line_start;
  logic        vga_stb;
  logic        vga_blank;
  logic [11:0] out_color;
  logic        out_rep;
  logic        ovf;
  modport master(
    output in_color, in_stb, in_line_start, vga_line_start, vga_stb, vga_blank,
    input  out_color, out_rep, ovf
  );
  modport slave(
    input  in_color, in_stb, in_line_start, vga_line_start, vga_stb, vga_blank,
    output out_color, out_rep, ovf
  );
endinterface

// File: rtl/video_scandbl_line.sv
// video_scandbl_line: ping-pong line buffer replaying each TV line twice at VGA rate
// SCANDBL_SCANLINES_EN: second replay (out_rep=1) is output at half intensity
module video_scandbl_line #(
  parameter int LINE_LEN = 896,
  parameter int AW       = 10
) (
  input logic clk,
  input logic rst,
  video_scandbl_line_if.slave vid
);
  localparam logic [AW:0] LL = LINE_LEN[AW:0];
  logic [11:0] mem [2][LINE_LEN];
  logic [AW:0] len [2];
  logic [AW:0] wr_addr, rd_addr, rd_len;
  logic        wr_bank, rd_bank, fresh, rep, ovf_r;
  logic [11:0] ram_q, out_color_r, shaded;
  logic        valid_q, stb_q, blank_q, out_rep_r;
  logic        nwb, nrb, we, re;
  logic [AW:0] wa, ra, nrl;
  // a coincident in_line_start is applied before the read side looks at the banks
  always_comb begin
    nwb = vid.in_line_start ? ~wr_bank : wr_bank;
    wa  = vid.in_line_start ? '0 : wr_addr;
    we  = !rst && vid.in_stb && wa < LL;
    nrb = vid.vga_line_start ? ~nwb : rd_bank;
    nrl = vid.vga_line_start ? (vid.in_line_start ? wr_addr : len[~wr_bank]) : rd_len;
    ra  = vid.vga_line_start ? '0 : rd_addr;
    re  = !rst && vid.vga_stb && ra < nrl;
`ifdef SCANDBL_SCANLINES_EN
    shaded = rep ? {1'b0, ram_q[11:9], 1'b0, ram_q[7:5], 1'b0, ram_q[3:1]} : ram_q;
`else
    shaded = ram_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (we) mem[nwb][wa[AW-1:0]] <= vid.in_color;
    if (re) ram_q <= mem[nrb][ra[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      wr_addr     <= '0;
      rd_addr     <= '0;
      rd_len      <= '0;
      len[0]      <= '0;
      len[1]      <= '0;
      rep         <= 1'b0;
      fresh       <= 1'b1;
      ovf_r       <= 1'b0;
      valid_q     <= 1'b0;
      stb_q       <= 1'b0;
      blank_q     <= 1'b0;
      out_color_r <= '0;
      out_rep_r   <= 1'b0;
    end else begin
      if (vid.in_line_start) len[wr_bank] <= wr_addr;
      wr_bank     <= nwb;
      wr_addr     <= we ? wa + 1'b1 : wa;
      ovf_r       <= ovf_r | (vid.in_stb & ~we);
      rd_bank     <= nrb;
      rd_len      <= nrl;
      rd_addr     <= vid.vga_stb && ra < LL ? ra + 1'b1 : ra;
      rep         <= vid.vga_line_start ? ~(fresh | vid.in_line_start) : rep;
      fresh       <= vid.vga_line_start ? 1'b0 : fresh | vid.in_line_start;
      stb_q       <= vid.vga_stb;
      valid_q     <= re;
      blank_q     <= vid.vga_blank;
      out_rep_r   <= rep;
      out_color_r <= blank_q ? '0 : stb_q ? (valid_q ? shaded : '0) : out_color_r;
    end
  end
  assign vid.out_color = out_color_r;
  assign vid.out_rep   = out_rep_r;
  assign vid.ovf       = ovf_r;
endmodule

// File: tb/tb_video_scandbl_line.sv
// tb_video_scandbl_line: directed and random line traffic checked against a line-level reference model
module tb_video_scandbl_line;
  localparam int LL = 896;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  video_scandbl_line_if bus();
  video_scandbl_line dut(.clk(clk), .rst(rst), .vid(bus));
  int checks = 0, errors = 0, cyc = 0;
  bit d_rst, d_ils, d_istb, d_vls, d_vstb, d_blank;
  logic [11:0] d_col;
  bit [11:0] m_mem [2][LL];
  int m_len [2];
  int m_wa, m_ra, m_rl;
  bit m_wb, m_rb, m_rep, m_fresh, m_ovf;
  bit s_stb [4], s_blank [4], s_rep [4], s_ovf [4];
  bit [11:0] s_val [4];
  bit [11:0] m_color;
  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  task automatic model_reset;
    m_wb = 0; m_rb = 1; m_wa = 0; m_ra = 0; m_rl = 0;
    m_len[0] = 0; m_len[1] = 0; m_rep = 0; m_fresh = 1; m_ovf = 0; m_color = 0;
    for (int i = 0; i < 4; i++) begin
      s_stb[i] = 0; s_blank[i] = 0; s_rep[i] = 0; s_ovf[i] = 0; s_val[i] = 0;
    end
  endtask
  // line-level rules: in_line_start first, then VGA line start, read old RAM data, then write
  task automatic model;
    bit [11:0] v;
    v = 0;
    if (d_rst) begin
      model_reset();
      return;
    end
    if (d_ils) begin
      m_len[m_wb] = m_wa; m_wb = !m_wb; m_wa = 0; m_fresh = 1;
    end
    if (d_vls) begin
      m_rb = !m_wb; m_rl = m_len[m_rb]; m_ra = 0; m_rep = !m_fresh; m_fresh = 0;
    end
    if (d_vstb) begin
      if (m_ra < m_rl) v = m_mem[m_rb][m_ra];
      if (m_ra < LL) m_ra++;
    end
    if (d_istb) begin
      if (m_wa < LL) begin
        m_mem[m_wb][m_wa] = d_col; m_wa++;
      end else m_ovf = 1;
    end
`ifdef SCANDBL_SCANLINES_EN
    if (m_rep) v = (v >> 1) & 12'h777;
`endif
    s_stb[(cyc + 2) % 4] = d_vstb;
    s_blank[(cyc + 2) % 4] = d_blank;
    s_val[(cyc + 2) % 4] = v;
    s_rep[(cyc + 2) % 4] = m_rep;
    s_ovf[(cyc + 1) % 4] = m_ovf;
  endtask
  task automatic tick;
    int k;
    @(negedge clk);
    k = cyc % 4;
    if (s_blank[k]) m_color = 0;
    else if (s_stb[k]) m_color = s_val[k];
    check("color", bus.out_color, m_color);
    check("rep", {11'd0, bus.out_rep}, {11'd0, s_rep[k]});
    check("ovf", {11'd0, bus.ovf}, {11'd0, s_ovf[k]});
    rst = d_rst;
    bus.in_line_start = d_ils; bus.in_stb = d_istb; bus.in_color = d_col;
    bus.vga_line_start = d_vls; bus.vga_stb = d_vstb; bus.vga_blank = d_blank;
    model();
    cyc++;
  endtask
  task automatic cycle(input bit ils, input bit istb, input logic [11:0] col,
                       input bit vls, input bit vstb, input bit blank);
    d_rst = 0; d_ils = ils; d_istb = istb; d_col = col;
    d_vls = vls; d_vstb = vstb; d_blank = blank;
    tick();
  endtask
  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 12'h000, 0, 0, 0);
  endtask
  // kind 0: colour = address, 1: constant c, 2: random
  task automatic capture(input int n, input int kind, input logic [11:0] c);
    cycle(1, 0, 12'h000, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      cycle(0, 1, kind == 0 ? 12'(i) : kind == 1 ? c : 12'($urandom), 0, 0, 0);
      idle(1);
    end
  endtask
  task automatic play(input int n);
    cycle(0, 0, 12'h000, 1, 1, 0);
    repeat (n - 1) cycle(0, 0, 12'h000, 0, 1, 0);
    idle(3);
  endtask
  task automatic random_phase(input int n);
    int til, tvl;
    bit ls;
    til = 0; tvl = 5; ls = 0;
    for (int i = 0; i < n; i++) begin
      d_rst = 0;
      d_ils = til == 0; d_vls = tvl == 0;
      til = til == 0 ? $urandom_range(2000, 400) : til - 1;
      tvl = tvl == 0 ? $urandom_range(1000, 200) : tvl - 1;
      d_istb = !ls && $urandom_range(1, 0) == 1; ls = d_istb;
      d_col = 12'($urandom);
      d_vstb = $urandom_range(3, 0) != 0;
      d_blank = $urandom_range(15, 0) == 0;
      tick();
    end
    idle(3);
  endtask
  initial begin
    rst = 1;
    bus.in_line_start = 0; bus.in_stb = 0; bus.in_color = 0;
    bus.vga_line_start = 0; bus.vga_stb = 0; bus.vga_blank = 0;
    model_reset();
    d_rst = 1; d_ils = 0; d_istb = 0; d_col = 0; d_vls = 0; d_vstb = 0; d_blank = 0;
    repeat (3) tick();
    idle(2);
    // first line after reset is black, then a full address-coloured line doubled
    capture(LL, 0, 12'h000);
    play(40);
    cycle(1, 0, 12'h000, 0, 0, 0);
    play(LL);
    play(LL);
    // short line, read past its end
    capture(10, 1, 12'hABC);
    cycle(1, 0, 12'h000, 0, 0, 0);
    play(20);
    play(20);
    // full-white line for the scanline shading
    capture(50, 1, 12'hFFF);
    cycle(1, 0, 12'h000, 0, 0, 0);
    play(50);
    play(50);
    play(50);
    // overflow: 900 pixels into one line
    capture(900, 0, 12'h000);
    cycle(1, 0, 12'h000, 0, 0, 0);
    play(LL);
    check("ovf_set", {11'd0, bus.ovf}, 12'd1);
    capture(30, 2, 12'h000);
    cycle(1, 0, 12'h000, 0, 0, 0);
    play(30);
    check("ovf_sticky", {11'd0, bus.ovf}, 12'd1);
    // simultaneous line starts and strobes on both sides
    capture(20, 1, 12'h5A5);
    cycle(1, 1, 12'h123, 1, 1, 0);
    for (int i = 1; i < 16; i++) begin
      idle(1);
      cycle(0, 1, 12'($urandom), 0, 1, 0);
    end
    cycle(1, 0, 12'h000, 0, 0, 0);
    play(16);
    random_phase(9000);
    // reset in the middle of a captured line
    capture(400, 2, 12'h000);
    d_rst = 1; d_ils = 0; d_istb = 0; d_vls = 0; d_vstb = 0; d_blank = 0;
    tick();
    @(posedge clk);
    #1;
    check("rst_color", bus.out_color, 12'h000);
    check("rst_ovf", {11'd0, bus.ovf}, 12'd0);
    play(100);
    capture(500, 2, 12'h000);
    cycle(1, 0, 12'h000, 0, 0, 0);
    play(500);
    play(500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
